// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - assembles opcode/operand command beats into one ALU operation and returns the captured result

package operation_pkg;
    typedef enum logic [7:0] {
        Operation_ADD = 8'd0,
        Operation_SUB = 8'd1,
        Operation_MUL = 8'd2,
        Operation_DIV = 8'd3
    } Operation;
endpackage

module alu_driver
    import operation_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [WIDTH-1:0]          cmd_data,
    output logic signed [WIDTH-1:0]   alu_in1,
    output logic signed [WIDTH-1:0]   alu_in2,
    output Operation                  alu_op,
    output logic                      alu_nvalid_data,
    input  logic signed [2*WIDTH-1:0] alu_out,
    input  logic                      alu_zero,
    input  logic                      alu_error,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic signed [2*WIDTH-1:0] rsp_data,
    output logic                      rsp_zero,
    output logic                      rsp_error,
    output logic [7:0]                err_count
);

    typedef enum logic [2:0] {
        GET_OP = 3'd0,
        GET_A  = 3'd1,
        GET_B  = 3'd2,
        EXEC   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    Operation                  op_q, op_d;
    logic signed [WIDTH-1:0]   in1_q, in1_d;
    logic signed [WIDTH-1:0]   in2_q, in2_d;
    logic signed [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      rsp_zero_q, rsp_zero_d;
    logic                      rsp_error_q, rsp_error_d;
    logic [7:0]                err_count_q, err_count_d;
    logic [7:0]                op_bits;
    logic                      cmd_xfer;
    logic                      rsp_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GET_OP;
            op_q        <= Operation_ADD;
            in1_q       <= '0;
            in2_q       <= '0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_error_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_error_q <= rsp_error_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_error_d = rsp_error_q;
        err_count_d = err_count_q;
        cmd_ready   = (state_q == GET_OP) || (state_q == GET_A) || (state_q == GET_B);
        cmd_xfer    = cmd_valid && cmd_ready;
        rsp_xfer    = (state_q == RESP) && rsp_ready;
        // Opcode is taken as-is; unknown encodings are left for the ALU to flag.
        op_bits     = 8'(cmd_data);

        case (state_q)
            GET_OP: begin
                if (cmd_xfer) begin
                    op_d    = Operation'(op_bits);
                    state_d = GET_A;
                end
            end
            GET_A: begin
                if (cmd_xfer) begin
                    in1_d   = cmd_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (cmd_xfer) begin
                    in2_d   = cmd_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_zero_d  = alu_zero;
                rsp_error_d = alu_error;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_xfer) begin
                    state_d = GET_OP;
                    if (rsp_error_q && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            default: state_d = GET_OP;
        endcase
    end

    assign alu_op          = op_q;
    assign alu_in1         = in1_q;
    assign alu_in2         = in2_q;
    assign alu_nvalid_data = (state_q != EXEC);
    assign rsp_valid       = (state_q == RESP);
    assign rsp_data        = rsp_data_q;
    assign rsp_zero        = rsp_zero_q;
    assign rsp_error       = rsp_error_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - directed self-checking bench for alu_driver with a behavioural ALU attached

module tb_alu_driver;
    import operation_pkg::*;

    localparam int W = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [W-1:0]          cmd_data;
    logic signed [W-1:0]   alu_in1;
    logic signed [W-1:0]   alu_in2;
    Operation              alu_op;
    logic                  alu_nvalid_data;
    logic signed [2*W-1:0] alu_out;
    logic                  alu_zero;
    logic                  alu_error;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic signed [2*W-1:0] rsp_data;
    logic                  rsp_zero;
    logic                  rsp_error;
    logic [7:0]            err_count;

    int checks = 0;
    int errors = 0;

    alu_driver #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_nvalid_data(alu_nvalid_data),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_error(rsp_error), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: divide by zero yields -1 with error, unknown opcode yields 0 with error.
    logic signed [2*W-1:0] ext_a, ext_b;
    always_comb begin
        ext_a     = {{W{alu_in1[W-1]}}, alu_in1};
        ext_b     = {{W{alu_in2[W-1]}}, alu_in2};
        alu_out   = '0;
        alu_error = 1'b0;
        case (alu_op)
            Operation_ADD: alu_out = ext_a + ext_b;
            Operation_SUB: alu_out = ext_a - ext_b;
            Operation_MUL: alu_out = ext_a * ext_b;
            Operation_DIV: begin
                if (ext_b == 0) begin
                    alu_out   = -16'sd1;
                    alu_error = 1'b1;
                end else begin
                    alu_out = ext_a / ext_b;
                end
            end
            default: alu_error = 1'b1;
        endcase
        alu_zero = (alu_out == 0);
    end

    // Called at a falling edge; returns at the falling edge after the beat transferred.
    task automatic send_beat(input logic [W-1:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL beat_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] ed, input logic ez, input logic ee, input bit hold);
        send_beat(op);
        send_beat(a);
        send_beat(b);
        checks++;
        if (alu_nvalid_data !== 1'b0) begin
            errors++; $display("FAIL exec_nvalid: got %b required 0", alu_nvalid_data);
        end
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL exec_handshake: rsp_valid=%b cmd_ready=%b required 0,0", rsp_valid, cmd_ready);
        end
        checks++;
        if (alu_op !== Operation'(op) || alu_in1 !== a || alu_in2 !== b) begin
            errors++;
            $display("FAIL operands: got op=%h in1=%h in2=%h required %h %h %h", alu_op, alu_in1, alu_in2, op, a, b);
        end
        @(negedge clk);
        checks++;
        if (alu_nvalid_data !== 1'b1 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL resp_state: nvalid=%b rsp_valid=%b required 1,1", alu_nvalid_data, rsp_valid);
        end
        checks++;
        if (rsp_data !== ed || rsp_zero !== ez || rsp_error !== ee) begin
            errors++;
            $display("FAIL resp_data: got data=%h zero=%b err=%b required %h %b %b", rsp_data, rsp_zero, rsp_error, ed, ez, ee);
        end
        if (!hold) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++; $display("FAIL resp_done: rsp_valid=%b cmd_ready=%b required 0,1", rsp_valid, cmd_ready);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (cmd_ready !== 1'b1 || alu_nvalid_data !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctl: cmd_ready=%b nvalid=%b rsp_valid=%b required 1,1,0", tag, cmd_ready, alu_nvalid_data, rsp_valid);
        end
        checks++;
        if (alu_op !== Operation_ADD || alu_in1 !== 8'sd0 || alu_in2 !== 8'sd0) begin
            errors++;
            $display("FAIL %s_alu: op=%h in1=%h in2=%h required 0,0,0", tag, alu_op, alu_in1, alu_in2);
        end
        checks++;
        if (rsp_data !== 16'h0 || rsp_zero !== 1'b0 || rsp_error !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL %s_rsp: data=%h zero=%b err=%b cnt=%0d required 0", tag, rsp_data, rsp_zero, rsp_error, err_count);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h02; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_release");
    endtask

    task automatic test_add;
        do_txn(8'h00, 8'h05, 8'hFD, 16'h0002, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mul_sub;
        do_txn(8'h02, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, 1'b0);
        do_txn(8'h01, 8'h07, 8'h07, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_errors;
        do_txn(8'h03, 8'h0A, 8'h00, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        checks++;
        if (err_count !== 8'd1) begin
            errors++; $display("FAIL err_count_div: got %0d required 1", err_count);
        end
        do_txn(8'hFF, 8'h01, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0);
        checks++;
        if (err_count !== 8'd2) begin
            errors++; $display("FAIL err_count_badop: got %0d required 2", err_count);
        end
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        do_txn(8'h00, 8'h03, 8'h04, 16'h0007, 1'b0, 1'b0, 1'b1);
        cmd_valid = 1'b1; cmd_data = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0007 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: rsp_valid=%b data=%h cmd_ready=%b required 1,0007,0", i, rsp_valid, rsp_data, cmd_ready);
            end
        end
        checks++;
        if (alu_op !== Operation_ADD || alu_in1 !== 8'sd3 || alu_in2 !== 8'sd4) begin
            errors++; $display("FAIL backpressure_consumed: op=%h in1=%h in2=%h required 0,3,4", alu_op, alu_in1, alu_in2);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: rsp_valid=%b cmd_ready=%b required 0,1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_gapped;
        send_beat(8'h01);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (alu_op !== Operation_SUB || cmd_ready !== 1'b1 || alu_nvalid_data !== 1'b1) begin
                errors++; $display("FAIL gap_op: op=%h cmd_ready=%b nvalid=%b required 1,1,1", alu_op, cmd_ready, alu_nvalid_data);
            end
        end
        send_beat(8'd20);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (alu_in1 !== 8'sd20 || alu_nvalid_data !== 1'b1) begin
                errors++; $display("FAIL gap_in1: in1=%0d nvalid=%b required 20,1", alu_in1, alu_nvalid_data);
            end
        end
        send_beat(8'd50);
        checks++;
        if (alu_nvalid_data !== 1'b0 || alu_in2 !== 8'sd50) begin
            errors++; $display("FAIL gap_exec: nvalid=%b in2=%0d required 0,50", alu_nvalid_data, alu_in2);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFE2 || rsp_zero !== 1'b0 || rsp_error !== 1'b0) begin
            errors++; $display("FAIL gap_resp: valid=%b data=%h zero=%b err=%b required 1,ffe2,0,0", rsp_valid, rsp_data, rsp_zero, rsp_error);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        send_beat(8'h02);
        send_beat(8'h09);
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_getb");
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(8'h00, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        do_txn(8'h03, 8'h0A, 8'h00, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_resp");
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        do_txn(8'h00, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 300; i++) begin
            do_txn(8'h03, 8'h01, 8'h00, 16'hFFFF, 1'b0, 1'b1, 1'b0);
            if (i == 254) begin
                checks++;
                if (err_count !== 8'd255) begin
                    errors++; $display("FAIL err_count_255: got %0d required 255", err_count);
                end
            end
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++; $display("FAIL err_count_sat: got %0d required 255", err_count);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_mul_sub();
        test_errors();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; all ALU and command data widths derive from it.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command beat present.
REQ-005 cmd_ready  output  1  block accepts a command beat this cycle.
REQ-006 cmd_data  input  WIDTH  command beat payload: opcode, in1, in2, in that order.
REQ-007 alu_in1  output  WIDTH  signed operand 1 to the ALU.
REQ-008 alu_in2  output  WIDTH  signed operand 2 to the ALU.
REQ-009 alu_op  output  Operation  opcode to the ALU, from operation_pkg.
REQ-010 alu_nvalid_data  output  1  active-high "operands not valid" to the ALU.
REQ-011 alu_out  input  2*WIDTH  signed ALU result.
REQ-012 alu_zero  input  1  ALU zero flag.
REQ-013 alu_error  input  1  ALU error flag.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_data  output  2*WIDTH  captured ALU result.
REQ-017 rsp_zero  output  1  captured zero flag.
REQ-018 rsp_error  output  1  captured error flag.
REQ-019 err_count  output  8  saturating count of responses with rsp_error=1.

Function
REQ-020 FSM states SHALL be GET_OP, GET_A, GET_B, EXEC, RESP; reset state GET_OP.
REQ-021 cmd_ready SHALL be 1 exactly in GET_OP, GET_A, GET_B; a beat transfers when cmd_valid && cmd_ready.
REQ-022 GET_OP: on transfer, latch alu_op = Operation'(cmd_data), no range check; go GET_A.
REQ-023 GET_A: on transfer, latch alu_in1 = cmd_data; go GET_B.
REQ-024 GET_B: on transfer, latch alu_in2 = cmd_data; go EXEC.
REQ-025 No transfer: state and latched fields hold.
REQ-026 alu_nvalid_data SHALL be 0 only while in EXEC, 1 in all other states.
REQ-027 EXEC lasts exactly one cycle; at its closing edge capture alu_out, alu_zero, alu_error into rsp_data, rsp_zero, rsp_error; go RESP.
REQ-028 Out-of-range opcode or in2==0 with DIV SHALL pass through unmodified; the error is whatever the ALU reports.
REQ-029 RESP: rsp_valid=1; rsp_data/zero/error stable until rsp_valid && rsp_ready; on that edge go GET_OP.
REQ-030 rsp_valid SHALL be 0 in all states except RESP.
REQ-031 Latency: in2 beat accepted at edge N -> EXEC cycle N..N+1 -> rsp_valid high from edge N+1; min command-to-command spacing 5 cycles with rsp_ready tied 1.
REQ-032 err_count increments by 1 on each response handshake with rsp_error=1; saturates at 255, no wrap.
REQ-033 alu_op, alu_in1, alu_in2 SHALL hold last latched values outside the latching cycle (no toggling while nvalid_data=1 except on beat transfer).
REQ-034 cmd_valid asserted during EXEC or RESP SHALL be ignored (not consumed, no state change).

Reset
REQ-035 rst_n=0 SHALL asynchronously force: state GET_OP, cmd_ready=1, alu_nvalid_data=1, alu_op=Operation_ADD, alu_in1=0, alu_in2=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_error=0, err_count=0.
REQ-036 Reset mid-transaction (any state) SHALL discard partial command and pending response; first beat after release is an opcode.
REQ-037 Reset release SHALL take effect synchronously to clk; no beat accepted in the release cycle's preceding edge.

Verification
REQ-038 Beats ADD,5,-3, rsp_ready=1 -> alu_nvalid_data low for exactly 1 cycle, rsp_data=2, rsp_zero=0, rsp_error=0, rsp_valid one cycle after in2 accepted.
REQ-039 Beats MUL,-128,-128 -> rsp_data=16384, error=0; SUB,7,7 -> rsp_data=0, rsp_zero=1.
REQ-040 Beats DIV,10,0 -> rsp_error=1, rsp_data=-1, err_count 0->1; opcode 0xFF,1,1 -> rsp_error=1, err_count 1->2.
REQ-041 Backpressure: rsp_ready=0 for 10 cycles with cmd_valid=1 -> rsp_valid and rsp_data hold, cmd_ready=0, no beat consumed; rsp_ready=1 -> handshake, GET_OP next.
REQ-042 Gapped cmd_valid (1 beat every 3 cycles) -> correct opcode/operand assembly, result matches ALU reference model.
REQ-043 rst_n pulsed low in GET_B and in RESP -> all outputs to REQ-035 values immediately; next ADD,1,1 gives rsp_data=2; 300 DIV-by-0 responses -> err_count=255.
